// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, ALU ops,
// instruction fields and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd13,
    S_EXCEPTION = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    ALU_LOAD = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_INC  = 3'd4,
    ALU_NEG  = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_COMP = 3'd7
  } alu_op_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // ALU B input selects
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // PC input selects
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // True for the R-type funct values that execute on the ALU
  function automatic logic is_alu_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_XOR) || (f == FN_SLT);
  endfunction

  // ALU operation for an R-type funct; decode already filtered illegal ones
  function automatic alu_op_t funct_alu_op(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_XOR:  return ALU_XOR;
      FN_SLT:  return ALU_COMP;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts cycles spent waiting on the shared memory; done marks the cycle
// on which read data is valid.
module mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [2:0] r_cnt;

  // Clear has priority so the count restarts at 0 on every new access
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_cnt <= 3'd0;
    else if (clear)  r_cnt <= 3'd0;
    else if (enable) r_cnt <= r_cnt + 3'd1;
  end

  assign done = (r_cnt == 3'(MEM_WAIT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: sequences the shared datapath through
// fetch/decode/execute/memory/write-back and drives every mux and enable.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state_out,
  output logic       halted
);

  state_t  r_state;
  state_t  w_next;
  alu_op_t w_alu_op;
  logic    w_in_wait;
  logic    w_done;

  // Counter runs only in the memory-wait states and is held at 0 elsewhere,
  // so it is already 0 on the first cycle of FETCH or MEM_READ.
  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM_READ);

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clock  (clock),
    .reset  (reset),
    .clear  (!w_in_wait || w_done),
    .enable (w_in_wait),
    .done   (w_done)
  );

  // State register; reset wins from any state, including mid-access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_next;
  end

  // Next-state and datapath controls; everything not set is 0
  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    w_alu_op   = ALU_LOAD;
    pc_source  = PCSRC_ALU;
    halted     = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        w_alu_op  = ALU_ADD;
        // IR and PC+4 latch only once the memory data is valid
        if (w_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        w_alu_op  = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (is_alu_funct(funct))   w_next = S_EXEC_R;
            else if (funct == FN_BREAK) w_next = S_HALT;
            else                        w_next = S_EXCEPTION;
          end
          OP_LW, OP_SW:    w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J:            w_next = S_JUMP;
          OP_ADDI:         w_next = S_ADDI_EXEC;
          default:         w_next = S_EXCEPTION;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALU_ADD;
        w_next    = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        iord = 1'b1;
        if (w_done) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        w_alu_op  = funct_alu_op(funct);
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        // Keep the ALU op so ALUOut stays meaningful during write-back
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_alu_op  = funct_alu_op(funct);
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        w_alu_op  = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        // Combinational from zero: the compare happens in this same cycle
        pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALU_ADD;
        w_next    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_EXCEPTION: begin
        halted = 1'b1;
      end
      // The unused encoding is treated as a fault
      default: w_next = S_EXCEPTION;
    endcase
  end

  assign alu_op    = w_alu_op;
  assign state_out = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (MEM_WAIT=2 and 0) run the
// same instruction table; expected per-cycle outputs go through a queue.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       halted;
  } outs_t;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct  = 6'h00;
  logic       zero   = 1'b0;

  logic pw2, io2, mw2, irw2, rw2, rd2, mr2, sa2, h2;
  logic [1:0] sb2, ps2;
  logic [2:0] ao2;
  logic [3:0] st2;
  logic pw0, io0, mw0, irw0, rw0, rd0, mr0, sa0, h0;
  logic [1:0] sb0, ps0;
  logic [2:0] ao0;
  logic [3:0] st0;
  outs_t o2, o0;

  always #5 clock = ~clock;

  multicycle_control_fsm #(.MEM_WAIT(2)) u_dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pw2), .iord(io2), .mem_write(mw2), .ir_write(irw2), .reg_write(rw2),
    .reg_dst(rd2), .mem_to_reg(mr2), .alu_src_a(sa2), .alu_src_b(sb2), .alu_op(ao2),
    .pc_source(ps2), .state_out(st2), .halted(h2));

  multicycle_control_fsm #(.MEM_WAIT(0)) u_dut0 (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pw0), .iord(io0), .mem_write(mw0), .ir_write(irw0), .reg_write(rw0),
    .reg_dst(rd0), .mem_to_reg(mr0), .alu_src_a(sa0), .alu_src_b(sb0), .alu_op(ao0),
    .pc_source(ps0), .state_out(st0), .halted(h0));

  assign o2 = {pw2, io2, mw2, irw2, rw2, rd2, mr2, sa2, sb2, ao2, ps2, st2, h2};
  assign o0 = {pw0, io0, mw0, irw0, rw0, rd0, mr0, sa0, sb0, ao0, ps0, st0, h0};

  int n_pass = 0;
  int n_chk  = 0;
  outs_t q2[$], q0[$], tq[$];
  vec_t  vt[16];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Expected outputs for one cycle in state s, written straight from the
  // per-state control table.
  function automatic outs_t eo(input int s, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input bit last);
    outs_t o = '0;
    o.state = 4'(s);
    case (s)
      1: begin
        o.alu_src_b = 2'd1; o.alu_op = 3'd1;
        o.ir_write = last; o.pc_write = last;
      end
      2: begin o.alu_src_b = 2'd3; o.alu_op = 3'd1; end
      3: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 3'd1; end
      4: o.iord = 1'b1;
      5: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      6: begin o.iord = 1'b1; o.mem_write = 1'b1; end
      7, 8: begin
        case (fn)
          6'h20: o.alu_op = 3'd1;
          6'h22: o.alu_op = 3'd2;
          6'h24: o.alu_op = 3'd3;
          6'h26: o.alu_op = 3'd6;
          6'h2A: o.alu_op = 3'd7;
          default: o.alu_op = 3'd0;
        endcase
        if (s == 7) o.alu_src_a = 1'b1;
        else begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      end
      9: begin
        o.alu_src_a = 1'b1; o.alu_op = 3'd2; o.pc_source = 2'd1;
        o.pc_write = (op == 6'h04) ? z : ~z;
      end
      10: begin o.pc_source = 2'd2; o.pc_write = 1'b1; end
      11: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 3'd1; end
      12: o.reg_write = 1'b1;
      13, 14: o.halted = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // Build the expected cycle trace of one instruction into tq
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z, input int mw);
    bit rfn;
    bit stop;
    tq.delete();
    stop = 1'b0;
    rfn = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h26) || (fn == 6'h2A);
    for (int i = 0; i <= mw; i++) tq.push_back(eo(1, op, fn, z, i == mw));
    tq.push_back(eo(2, op, fn, z, 1'b0));
    if (op == 6'h00 && rfn) begin
      tq.push_back(eo(7, op, fn, z, 1'b0));
      tq.push_back(eo(8, op, fn, z, 1'b0));
    end else if (op == 6'h00 && fn == 6'h0D) begin
      repeat (20) tq.push_back(eo(13, op, fn, z, 1'b0));
      stop = 1'b1;
    end else if (op == 6'h23) begin
      tq.push_back(eo(3, op, fn, z, 1'b0));
      for (int i = 0; i <= mw; i++) tq.push_back(eo(4, op, fn, z, 1'b0));
      tq.push_back(eo(5, op, fn, z, 1'b0));
    end else if (op == 6'h2B) begin
      tq.push_back(eo(3, op, fn, z, 1'b0));
      tq.push_back(eo(6, op, fn, z, 1'b0));
    end else if (op == 6'h04 || op == 6'h05) begin
      tq.push_back(eo(9, op, fn, z, 1'b0));
    end else if (op == 6'h02) begin
      tq.push_back(eo(10, op, fn, z, 1'b0));
    end else if (op == 6'h08) begin
      tq.push_back(eo(11, op, fn, z, 1'b0));
      tq.push_back(eo(12, op, fn, z, 1'b0));
    end else begin
      repeat (20) tq.push_back(eo(14, op, fn, z, 1'b0));
      stop = 1'b1;
    end
    // After completing, the next instruction fetch must start afresh
    if (!stop) tq.push_back(eo(1, op, fn, z, mw == 0));
  endtask

  initial begin
    outs_t e;
    int cyc;
    vt[0]  = '{"add",   6'h00, 6'h20, 1'b0};
    vt[1]  = '{"sub",   6'h00, 6'h22, 1'b0};
    vt[2]  = '{"and",   6'h00, 6'h24, 1'b0};
    vt[3]  = '{"xor",   6'h00, 6'h26, 1'b0};
    vt[4]  = '{"slt",   6'h00, 6'h2A, 1'b1};
    vt[5]  = '{"lw",    6'h23, 6'h00, 1'b0};
    vt[6]  = '{"sw",    6'h2B, 6'h00, 1'b0};
    vt[7]  = '{"beq_z1",6'h04, 6'h00, 1'b1};
    vt[8]  = '{"beq_z0",6'h04, 6'h00, 1'b0};
    vt[9]  = '{"bne_z1",6'h05, 6'h00, 1'b1};
    vt[10] = '{"bne_z0",6'h05, 6'h00, 1'b0};
    vt[11] = '{"j",     6'h02, 6'h00, 1'b0};
    vt[12] = '{"addi",  6'h08, 6'h3F, 1'b1};
    vt[13] = '{"illop", 6'h3F, 6'h20, 1'b0};
    vt[14] = '{"break", 6'h00, 6'h0D, 1'b0};
    vt[15] = '{"badfn", 6'h00, 6'h21, 1'b0};

    // Table-driven instruction traces on both instances
    foreach (vt[k]) begin
      @(negedge clock);
      reset = 1'b1;
      opcode = vt[k].op; funct = vt[k].fn; zero = vt[k].z;
      @(negedge clock);
      check({vt[k].nm, "_rst2"}, 32'(o2), 32'(outs_t'('0)));
      check({vt[k].nm, "_rst0"}, 32'(o0), 32'(outs_t'('0)));
      gen(vt[k].op, vt[k].fn, vt[k].z, 2); q2 = tq;
      gen(vt[k].op, vt[k].fn, vt[k].z, 0); q0 = tq;
      reset = 1'b0;
      cyc = 0;
      while (q2.size() != 0 || q0.size() != 0) begin
        @(negedge clock);
        cyc++;
        if (q2.size() != 0) begin
          e = q2.pop_front();
          check($sformatf("%s_w2_c%0d", vt[k].nm, cyc), 32'(o2), 32'(e));
        end
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check($sformatf("%s_w0_c%0d", vt[k].nm, cyc), 32'(o0), 32'(e));
        end
      end
    end

    // Reset asserted in the second MEM_READ cycle of a lw (MEM_WAIT=2)
    @(negedge clock);
    reset = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (7) @(negedge clock);
    check("midread_state", 32'(st2), 32'd4);
    reset = 1'b1;
    #1;
    check("midread_async_rst", 32'(o2), 32'(outs_t'('0)));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midread_refetch1", 32'(o2), 32'(eo(1, 6'h23, 6'h00, 1'b0, 1'b0)));
    @(negedge clock);
    check("midread_refetch2", 32'(o2), 32'(eo(1, 6'h23, 6'h00, 1'b0, 1'b0)));
    @(negedge clock);
    check("midread_refetch3", 32'(o2), 32'(eo(1, 6'h23, 6'h00, 1'b0, 1'b1)));

    // Branch decision follows zero within the BRANCH cycle
    @(negedge clock);
    reset = 1'b1; opcode = 6'h04; zero = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("beq_comb_state", 32'(st2), 32'd9);
    check("beq_comb_z0", 32'(pw2), 32'd0);
    zero = 1'b1;
    #1;
    check("beq_comb_z1", 32'(pw2), 32'd1);

    // EXCEPTION is left only through reset
    @(negedge clock);
    reset = 1'b1; opcode = 6'h3F;
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("exc_hold_state", 32'(st2), 32'd14);
    check("exc_hold_halted", 32'(h2), 32'd1);
    reset = 1'b1;
    #1;
    check("exc_release", 32'(st2), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("exc_to_fetch", 32'(st2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
